eth_tx_arb: RTL and testbench
=============================

// Module: eth_tx_arb
// PURPOSE
//  Packet-level 2:1 round-robin arbiter sharing the 10G MAC TX AXI-Stream (64b, clk156 domain)
//  between source 0 (TLP encapsulation path) and source 1 (test frame generator).
//  Once granted, a source owns the MAC until its tlast beat; never interleaves frames.
//  Stall watchdog: a granted source that stalls mid-frame is cut off with an error-terminated beat.
// PARAMETERS
//  TIMEOUT_CYC  1024  idle-source cycles mid-frame before abort; 0 disables watchdog (range 0..65535)
// PORTS
//  clk156          in   1   156.25 MHz MAC core clock; sole clock
//  sys_rst_n       in   1   synchronous, active-low reset
//  s0_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  source 0 AXIS
//  s1_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  source 1 AXIS
//  m_axis_tvalid/tready/tdata/tkeep/tlast/tuser   out/in/out/out/out/out  1/1/64/8/1/1  to MAC TX
//  grant           out  2   one-hot current owner (00 = none)
//  abort_pulse     out  1   1-cycle pulse when abort beat is accepted by MAC
// BEHAVIOUR
//  Reset: state IDLE, grant=00, rr pointer=0 (source 0 preferred), m_axis_tvalid=0, s*_tready=0,
//   m_axis_tdata/tkeep/tlast/tuser=0, abort_pulse=0, watchdog counter=0. Reset mid-frame drops ownership.
//  IDLE: m_axis_tvalid=0, all s*_tready=0. If any s*_tvalid: grant registered next edge -> PASS.
//   Both valid: pick source == rr pointer. One valid: pick it. Arbitration latency 1 cycle.
//  PASS: combinational pass-through of granted source: m_axis_* = sg_axis_*, sg_tready = m_axis_tready;
//   ungranted tready=0, m_axis_* zeroed when not from grant. Handshake = m_tvalid & m_tready.
//   Handshake with tlast -> IDLE, rr pointer = other source, grant=00 on next cycle.
//  Watchdog (PASS only, TIMEOUT_CYC>0): 16b counter increments each cycle sg_tvalid=0; cleared on any
//   handshake and on entering PASS; MAC backpressure (tvalid=1,tready=0) does not count.
//   Counter == TIMEOUT_CYC-1 while sg_tvalid=0 -> ABORT. Source reasserting tvalid that cycle wins (no abort).
//  ABORT: m_axis_tvalid=1, tdata=0, tkeep=8'h01, tlast=1, tuser=1 (MAC marks frame bad); all s*_tready=0.
//   On m_axis_tready: abort_pulse=1 for that cycle, -> DRAIN.
//  DRAIN: m_axis_tvalid=0; sg_tready=1, beats discarded; accepted beat with tlast -> IDLE, rr flips.
//  Granted source tlast with tuser=1 passes unmodified. tkeep passed unmodified (no checking).
//  Ungranted source may hold tvalid indefinitely; must not be starved >1 frame when other source busy.
// CONFIGURATION
//  ETH_TX_ARB_STATS_EN defined: adds outputs frames0_cnt[31:0], frames1_cnt[31:0] (increment on tlast
//   handshake in PASS per source, wrap at 2^32) and abort_cnt[15:0] (saturates at 16'hFFFF);
//   all clear on sys_rst_n=0. Undefined: these ports and counters do not exist; behaviour otherwise identical.
// STRUCTURE
//  eth_tx_arb_pkg: typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} arb_state_t; localparams
//   AXIS_DATA_W=64, AXIS_KEEP_W=8, WDOG_W=16; struct axis_beat_t {tdata,tkeep,tlast,tuser}.
//  Sub-module eth_tx_arb_rr: 2-way round-robin pick (req[1:0], ptr) -> one-hot gnt, combinational.
//  Top holds FSM, grant/rr registers, watchdog, output mux, optional stats.
// TESTING
//  1. s0 sends 3-beat frame, s1 idle, m_tready=1 -> grant=01 one cycle after s0_tvalid, 3 beats
//     out unchanged, grant=00 after tlast.
//  2. s0 and s1 both valid from reset, 2 frames each -> output order s0,s1,s0,s1; no beat interleave.
//  3. m_tready toggled 1/0 every cycle during a 8-beat s1 frame, TIMEOUT_CYC=4 -> no abort, all 8 beats intact.
//  4. TIMEOUT_CYC=4, s0 sends 2 beats then drops tvalid -> after 4 stall cycles m_axis beat tkeep=8'h01
//     tlast=1 tuser=1, abort_pulse=1; s0 remaining beats accepted but not forwarded; next grant goes to s1.
//  5. sys_rst_n pulled low mid-frame of s1 -> next cycle m_tvalid=0, grant=00; following arbitration favours s0.
//  6. STATS_EN build: run tests 2 and 4 -> frames0_cnt=2, frames1_cnt=2, abort_cnt=1 after each respectively.

Source files
------------

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and widths for the 2:1 packet arbiter in front of the 10G MAC TX stream.
package eth_tx_arb_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;
  localparam int WDOG_W      = 16;

  typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} arb_state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic                   tuser;
  } axis_beat_t;

  // Error-terminated beat: MAC flags the truncated frame as bad via tuser.
  localparam axis_beat_t ABORT_BEAT = '{tdata: '0, tkeep: 8'h01, tlast: 1'b1, tuser: 1'b1};

endpackage

// File: rtl/eth_tx_arb_if.sv
// AXI-Stream link (64b data, byte keep, last, user error flag) with producer/consumer modports.
interface eth_tx_arb_if;
  import eth_tx_arb_pkg::*;

  logic                   tvalid;
  logic                   tready;
  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tlast;
  logic                   tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/eth_tx_arb_rr.sv
// Two-way round-robin pick: the pointer breaks ties, a lone requester always wins.
module eth_tx_arb_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level 2:1 round-robin arbiter onto the MAC TX stream with a mid-frame stall watchdog.
// Optional build macro ETH_TX_ARB_STATS_EN adds per-source frame counters and an abort counter.
//
//   state | meaning
//   IDLE  | no owner, outputs quiet, arbitrate among valid sources
//   PASS  | granted source wired straight through to the MAC
//   ABORT | stalled owner cut off; error-terminated beat offered to MAC
//   DRAIN | discard the rest of the aborted frame up to its tlast
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  eth_tx_arb_if.slave  s0_axis,
  eth_tx_arb_if.slave  s1_axis,
  eth_tx_arb_if.master m_axis,
  output logic [1:0]  grant,
  output logic        abort_pulse
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [31:0] frames0_cnt,
  output logic [31:0] frames1_cnt,
  output logic [15:0] abort_cnt
`endif
);

  localparam bit WDOG_EN = (TIMEOUT_CYC != 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'((TIMEOUT_CYC == 0) ? 32'd0 : TIMEOUT_CYC - 32'd1);

  arb_state_t        state;
  logic              rr_ptr;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [1:0]        rr_gnt;

  axis_beat_t s0_beat, s1_beat, sg_beat, m_beat;
  logic       sg_tvalid, sg_tready, m_tvalid;
  logic       m_hs, sg_hs, wdog_fire;

  assign s0_beat   = {s0_axis.tdata, s0_axis.tkeep, s0_axis.tlast, s0_axis.tuser};
  assign s1_beat   = {s1_axis.tdata, s1_axis.tkeep, s1_axis.tlast, s1_axis.tuser};
  assign sg_beat   = grant[1] ? s1_beat : s0_beat;
  assign sg_tvalid = grant[1] ? s1_axis.tvalid : (grant[0] & s0_axis.tvalid);

  eth_tx_arb_rr u_rr (
    .req ({s1_axis.tvalid, s0_axis.tvalid}),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    m_tvalid  = 1'b0;
    m_beat    = '0;
    sg_tready = 1'b0;
    case (state)
      PASS: begin
        m_tvalid  = sg_tvalid;
        m_beat    = sg_beat;
        sg_tready = m_axis.tready;
      end
      ABORT: begin
        m_tvalid = 1'b1;
        m_beat   = ABORT_BEAT;
      end
      DRAIN:   sg_tready = 1'b1;
      default: ;
    endcase
  end

  assign m_axis.tvalid  = m_tvalid;
  assign m_axis.tdata   = m_beat.tdata;
  assign m_axis.tkeep   = m_beat.tkeep;
  assign m_axis.tlast   = m_beat.tlast;
  assign m_axis.tuser   = m_beat.tuser;
  assign s0_axis.tready = sg_tready & grant[0];
  assign s1_axis.tready = sg_tready & grant[1];

  assign m_hs        = m_tvalid & m_axis.tready;
  assign sg_hs       = sg_tvalid & sg_tready;
  assign abort_pulse = (state == ABORT) & m_axis.tready;
  // A source that reasserts tvalid in the expiry cycle keeps its frame.
  assign wdog_fire   = WDOG_EN && (state == PASS) && !sg_tvalid && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      grant    <= 2'b00;
      rr_ptr   <= 1'b0;
      wdog_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_gnt != 2'b00) begin
            grant    <= rr_gnt;
            state    <= PASS;
            wdog_cnt <= '0;
          end
        end
        PASS: begin
          if (m_hs && sg_beat.tlast) begin
            state    <= IDLE;
            grant    <= 2'b00;
            rr_ptr   <= grant[0];
            wdog_cnt <= '0;
          end else if (wdog_fire) begin
            state <= ABORT;
          end else if (sg_hs) begin
            wdog_cnt <= '0;
          end else if (!sg_tvalid && WDOG_EN) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        ABORT: begin
          if (m_axis.tready) state <= DRAIN;
        end
        DRAIN: begin
          if (sg_hs && sg_beat.tlast) begin
            state  <= IDLE;
            grant  <= 2'b00;
            rr_ptr <= grant[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      frames0_cnt <= '0;
      frames1_cnt <= '0;
      abort_cnt   <= '0;
    end else begin
      if (state == PASS && m_hs && sg_beat.tlast) begin
        if (grant[0]) frames0_cnt <= frames0_cnt + 32'd1;
        if (grant[1]) frames1_cnt <= frames1_cnt + 32'd1;
      end
      if (abort_pulse && abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed self-checking bench for eth_tx_arb (watchdog shortened to 4 cycles).
module tb_eth_tx_arb;
  import eth_tx_arb_pkg::*;

  logic clk156 = 1'b0;
  logic sys_rst_n;
  always #5 clk156 = ~clk156;

  eth_tx_arb_if s0_if ();
  eth_tx_arb_if s1_if ();
  eth_tx_arb_if m_if ();

  logic [1:0] grant;
  logic       abort_pulse;
`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0] frames0_cnt, frames1_cnt;
  logic [15:0] abort_cnt;
`endif

  eth_tx_arb #(.TIMEOUT_CYC(4)) dut (
    .clk156      (clk156),
    .sys_rst_n   (sys_rst_n),
    .s0_axis     (s0_if),
    .s1_axis     (s1_if),
    .m_axis      (m_if),
    .grant       (grant),
    .abort_pulse (abort_pulse)
`ifdef ETH_TX_ARB_STATS_EN
    ,
    .frames0_cnt (frames0_cnt),
    .frames1_cnt (frames1_cnt),
    .abort_cnt   (abort_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_abort = 0;
  axis_beat_t s0_q[$], s1_q[$], out_q[$], exp_q[$];
  bit s0_en = 1'b1, s1_en = 1'b1, tog_en = 1'b0;
  bit hs0, hs1;

  function automatic axis_beat_t mk(int src, int frm, int idx, bit last);
    axis_beat_t b;
    b.tdata = {32'hC0DE_0000, 8'(src), 8'(frm), 16'(idx)};
    b.tkeep = last ? 8'h0F : 8'hFF;
    b.tlast = last;
    b.tuser = last && (frm == 1);
    return b;
  endfunction

  task automatic push_frame(int src, int frm, int len, bit to_exp);
    axis_beat_t b;
    for (int i = 0; i < len; i++) begin
      b = mk(src, frm, i, i == len - 1);
      if (src == 0) s0_q.push_back(b);
      else          s1_q.push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
  endtask

  task automatic drive();
    axis_beat_t zb;
    zb = '0;
    s0_if.tvalid = s0_en && (s0_q.size() != 0);
    s1_if.tvalid = s1_en && (s1_q.size() != 0);
    {s0_if.tdata, s0_if.tkeep, s0_if.tlast, s0_if.tuser} = (s0_q.size() != 0) ? s0_q[0] : zb;
    {s1_if.tdata, s1_if.tkeep, s1_if.tlast, s1_if.tuser} = (s1_q.size() != 0) ? s1_q[0] : zb;
  endtask

  // Sample everything at the falling edge, advance sources just after the rising edge.
  task automatic tick();
    axis_beat_t b;
    @(negedge clk156);
    hs0 = s0_if.tvalid && s0_if.tready;
    hs1 = s1_if.tvalid && s1_if.tready;
    if (m_if.tvalid && m_if.tready)
      out_q.push_back({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser});
    if (abort_pulse) n_abort++;
    @(posedge clk156);
    #1;
    if (hs0) b = s0_q.pop_front();
    if (hs1) b = s1_q.pop_front();
    if (tog_en) m_if.tready = !m_if.tready;
    drive();
    #1;
  endtask

  task automatic run_until(int n, int budget, output bit ok);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (out_q.size() >= n);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    s0_q.delete(); s1_q.delete(); exp_q.delete();
    s0_en = 1'b1; s1_en = 1'b1; tog_en = 1'b0;
    m_if.tready = 1'b1;
    drive();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    out_q.delete();
    n_abort = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_tests++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b want 0", m_if.tvalid); end
    n_tests++;
    if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== 74'd0) begin
      n_fail++; $display("FAIL reset_mbeat: got %h/%h/%b/%b want zeros", m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser);
    end
    n_tests++;
    if ({s0_if.tready, s1_if.tready, abort_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready_abort: got %b%b%b want 000", s0_if.tready, s1_if.tready, abort_pulse);
    end
`ifdef ETH_TX_ARB_STATS_EN
    n_tests++;
    if (frames0_cnt !== 32'd0 || frames1_cnt !== 32'd0 || abort_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", frames0_cnt, frames1_cnt, abort_cnt);
    end
`endif
  endtask

  task automatic test_single_frame();
    bit ok;
    push_frame(0, 0, 3, 1'b1);
    drive();
    #1;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL t1_grant_latency: got %b want 00", grant); end
    tick();
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL t1_grant: got %b want 01", grant); end
    n_tests++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_q[0].tdata || s1_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL t1_first_beat: got v=%b d=%h r1=%b want v=1 d=%h r1=0", m_if.tvalid, m_if.tdata, s1_if.tready, exp_q[0].tdata);
    end
    run_until(3, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_timeout: got %0d beats want 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t1_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL t1_grant_release: got %b want 00", grant); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    push_frame(0, 0, 2, 1'b1);
    push_frame(1, 0, 3, 1'b1);
    push_frame(0, 1, 3, 1'b1);
    push_frame(1, 1, 2, 1'b1);
    drive();
    #1;
    run_until(10, 80, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t2_timeout: got %0d beats want 10", out_q.size()); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t2_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
`ifdef ETH_TX_ARB_STATS_EN
    n_tests++;
    if (frames0_cnt !== 32'd2 || frames1_cnt !== 32'd2) begin
      n_fail++; $display("FAIL t2_stats: got %0d/%0d want 2/2", frames0_cnt, frames1_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit ok;
    out_q.delete(); exp_q.delete(); n_abort = 0;
    push_frame(1, 2, 8, 1'b1);
    tog_en = 1'b1;
    drive();
    #1;
    run_until(8, 60, ok);
    tog_en = 1'b0;
    m_if.tready = 1'b1;
    tick();
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t3_timeout: got %0d beats want 8", out_q.size()); end
    n_tests++; if (out_q.size() != 8) begin n_fail++; $display("FAIL t3_count: got %0d want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t3_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    n_tests++; if (n_abort != 0) begin n_fail++; $display("FAIL t3_no_abort: got %0d aborts want 0", n_abort); end
  endtask

  task automatic test_watchdog();
    bit ok;
    do_reset();
    push_frame(0, 3, 5, 1'b0);
    push_frame(1, 3, 2, 1'b0);
    push_frame(0, 4, 1, 1'b0);
    exp_q.push_back(mk(0, 3, 0, 1'b0));
    exp_q.push_back(mk(0, 3, 1, 1'b0));
    exp_q.push_back(ABORT_BEAT);
    exp_q.push_back(mk(1, 3, 0, 1'b0));
    exp_q.push_back(mk(1, 3, 1, 1'b1));
    exp_q.push_back(mk(0, 4, 0, 1'b1));
    drive();
    #1;
    run_until(2, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t4_pre_timeout: got %0d beats want 2", out_q.size()); end
    s0_en = 1'b0;
    drive();
    #1;
    repeat (3) tick();
    n_tests++;
    if (m_if.tvalid !== 1'b0 || grant !== 2'b01) begin
      n_fail++; $display("FAIL t4_no_early_abort: got v=%b g=%b want v=0 g=01", m_if.tvalid, grant);
    end
    tick();
    n_tests++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 64'd0 || m_if.tkeep !== 8'h01 || m_if.tlast !== 1'b1 || m_if.tuser !== 1'b1) begin
      n_fail++; $display("FAIL t4_abort_beat: got v=%b d=%h k=%h l=%b u=%b want 1/0/01/1/1", m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser);
    end
    n_tests++;
    if (abort_pulse !== 1'b1 || s0_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL t4_abort_pulse: got p=%b r0=%b want p=1 r0=0", abort_pulse, s0_if.tready);
    end
    s0_en = 1'b1;
    drive();
    #1;
    run_until(6, 60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t4_post_timeout: got %0d beats want 6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL t4_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    n_tests++; if (n_abort != 1) begin n_fail++; $display("FAIL t4_abort_count: got %0d want 1", n_abort); end
    n_tests++; if (s0_q.size() != 0) begin n_fail++; $display("FAIL t4_drained: got %0d left want 0", s0_q.size()); end
`ifdef ETH_TX_ARB_STATS_EN
    n_tests++; if (abort_cnt !== 16'd1) begin n_fail++; $display("FAIL t4_stats_abort: got %0d want 1", abort_cnt); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    out_q.delete(); exp_q.delete();
    push_frame(1, 5, 6, 1'b0);
    drive();
    #1;
    run_until(2, 20, ok);
    n_tests++; if (!ok || grant !== 2'b10) begin n_fail++; $display("FAIL t5_s1_owner: got %0d beats g=%b want 2 beats g=10", out_q.size(), grant); end
    push_frame(0, 5, 1, 1'b0);
    drive();
    #1;
    sys_rst_n = 1'b0;
    tick();
    n_tests++;
    if (m_if.tvalid !== 1'b0 || grant !== 2'b00 || s1_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL t5_reset_drop: got v=%b g=%b r1=%b want 0/00/0", m_if.tvalid, grant, s1_if.tready);
    end
    sys_rst_n = 1'b1;
    tick();
    n_tests++;
    if (grant !== 2'b01 || m_if.tdata !== mk(0, 5, 0, 1'b1).tdata) begin
      n_fail++; $display("FAIL t5_rr_after_reset: got g=%b d=%h want g=01 d=%h", grant, m_if.tdata, mk(0, 5, 0, 1'b1).tdata);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    m_if.tready = 1'b1;
    drive();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
